axi4l_master_engine: RTL and testbench
======================================

# axi4l_master_engine

Synthesisable AXI4-lite master that turns a simple command/response stream into single AXI4-lite read or write transactions, one outstanding at a time. It replaces testbench-only register access with a parametrised RTL engine usable by on-chip controllers (e.g. NTP config sequencers) and by benches alike. It adds per-command byte strobes, full response codes, response back-pressure and an optional hung-slave timeout.

## Interface
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64); strobe width DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, cycles in a bus phase before timeout (used only with timeout compiled in; ≥2)
- Clocking (already decided): one clock, M_AXI_ACLK; reset M_AXI_ARESETN is asynchronous and active-low.
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESETN  in  1  async active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata / cmd_wstrb  in  DATA_WIDTH / DATA_WIDTH/8  write data, byte enables
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echo of cmd_write
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or SLVERR on timeout
- rsp_timeout  out  1  response generated by timeout
- M_AXI_AW*/W*/B*/AR*/R*  per AXI4-lite  master-side channels (AWPROT 3'b000, ARPROT 3'b001 constant)

## Operation
- States: IDLE, WRITE, READ, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, register command; write → WRITE, read → READ.
- WRITE: AWVALID, WVALID and BREADY asserted. AWVALID drops the cycle after AWREADY sampled high; WVALID independently after WREADY; either may complete first or together. When BVALID&&BREADY: capture BRESP, drop BREADY → RESP.
- READ: ARVALID, RREADY asserted; ARVALID drops after ARREADY. On RVALID&&RREADY: capture RDATA, RRESP → RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready; then IDLE. Back-pressure holds the engine; no new command accepted.
- Address/data/strobe held stable while corresponding VALID high.
- Reset (any time, incl. mid-transaction): all VALID/READY outputs 0, cmd_ready 0, rsp_valid 0, rsp_* 0, addresses/data 0, state IDLE; in-flight transaction discarded.

## Timing
- cmd_ready rises first clock edge after reset release.
- Min write latency (zero-wait slave): accept edge 0, AW/W valid from edge 1, BVALID edge 2, rsp_valid edge 3. Read identical.
- cmd_ready returns the edge after rsp handshake; back-to-back command possible then (one idle cycle between transactions minimum).
- All outputs registered; no combinational path from AXI inputs to AXI outputs.

## Configuration
- AXI4L_MASTER_TIMEOUT_EN defined: counter restarts on entering WRITE/READ, counts every cycle there; at TIMEOUT_CYCLES without completion, all VALID/READY drop, rsp_resp=2'b10, rsp_timeout=1, → RESP. Late slave responses ignored (READY low). Deliberate protocol break for hung-slave recovery only.
- Not defined: no counter; engine waits indefinitely; rsp_timeout tied 0.

## Structure
- axi4l_master_pkg: state enum, resp constants (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11), AWPROT/ARPROT defaults.
- Sub-module axi4l_timeout_counter (clear/enable/expired, width $clog2(TIMEOUT_CYCLES+1)), instantiated only under the macro.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF, wstrb 4'hF, zero-wait slave → rsp_valid at edge 3, rsp_resp 00, rsp_write 1.
- Write with AWREADY 3 cycles after WREADY, wstrb 4'b0101 → each VALID drops individually, slave sees strobe 0101, single response.
- Read 0x0000_0020, slave returns 0x1234_5678 RRESP 10 after 5 waits → rsp_rdata 0x1234_5678, rsp_resp 10.
- rsp_ready held low 10 cycles → rsp stable, cmd_ready 0 throughout, next command accepted edge after handshake.
- Reset asserted while WVALID high → all outputs 0 asynchronously; after release cmd_ready 1 next edge, new write completes normally.
- With AXI4L_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts ARREADY → response after 16 cycles, rsp_resp 10, rsp_timeout 1, ARVALID 0.

Source files
------------

// File: rtl/axi4l_master_pkg.sv
// Shared types and constants for the AXI4-lite master engine.
package axi4l_master_pkg;

    // Engine sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // AXI BRESP/RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Fixed protection attributes driven on every transaction
    localparam logic [2:0] AWPROT_DEFAULT = 3'b000;
    localparam logic [2:0] ARPROT_DEFAULT = 3'b001;

endpackage

// File: rtl/axi4l_master_engine_if.sv
// AXI4-lite channel bundle between the master engine and a slave.
interface axi4l_master_engine_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp, output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );

endinterface

// File: rtl/axi4l_timeout_counter.sv
// Bus-phase watchdog: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed. The flag is
// registered one cycle early so the consumer acts on exactly the
// TIMEOUT_CYCLES-th cycle; this is why TIMEOUT_CYCLES must be >= 2.
module axi4l_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] count_q;
    logic             expired_q;

    // Saturating cycle count with sticky early-registered expiry flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (clear_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else if (enable_i) begin
            if (count_q != CNT_MAX) begin
                count_q <= count_q + CNT_W'(1);
            end
            expired_q <= expired_q | (count_q == LAST_WAIT);
        end else begin
            expired_q <= 1'b0;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/axi4l_master_engine.sv
// AXI4-lite master: converts a cmd/rsp stream into single AXI4-lite
// transactions, one outstanding at a time.
// Optional hung-slave timeout: define AXI4L_MASTER_TIMEOUT_EN.
module axi4l_master_engine
    import axi4l_master_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    rsp_timeout,

    axi4l_master_engine_if.master   m_axi
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  bready_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) && cmd_ready_q && cmd_valid;

`ifdef AXI4L_MASTER_TIMEOUT_EN
    logic rsp_timeout_q;
    logic to_enable;
    logic to_expired;

    assign to_enable = (state_q == ST_WRITE) || (state_q == ST_READ);

    // Watchdog restarted at each accepted command, running during bus phases
    axi4l_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (M_AXI_ACLK),
        .rst_n     (M_AXI_ARESETN),
        .clear_i   (accept),
        .enable_i  (to_enable),
        .expired_o (to_expired)
    );

    assign rsp_timeout = rsp_timeout_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign rsp_timeout = 1'b0;
`endif

    // Transaction sequencer with all bus and response outputs registered
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
`ifdef AXI4L_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr;
                        if (cmd_write) begin
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            bready_q  <= 1'b1;
                            state_q   <= ST_WRITE;
                        end else begin
                            arvalid_q <= 1'b1;
                            rready_q  <= 1'b1;
                            state_q   <= ST_READ;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                ST_WRITE: begin
                    // Address and data channels retire independently
                    if (awvalid_q && m_axi.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && m_axi.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (bready_q && m_axi.bvalid) begin
                        awvalid_q   <= 1'b0;
                        wvalid_q    <= 1'b0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_resp_q  <= m_axi.bresp;
                        state_q     <= ST_RESP;
                    end
`ifdef AXI4L_MASTER_TIMEOUT_EN
                    else if (to_expired) begin
                        awvalid_q     <= 1'b0;
                        wvalid_q      <= 1'b0;
                        bready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end
`endif
                end

                ST_READ: begin
                    if (arvalid_q && m_axi.arready) begin
                        arvalid_q <= 1'b0;
                    end
                    if (rready_q && m_axi.rvalid) begin
                        arvalid_q   <= 1'b0;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= 1'b0;
                        rsp_rdata_q <= m_axi.rdata;
                        rsp_resp_q  <= m_axi.rresp;
                        state_q     <= ST_RESP;
                    end
`ifdef AXI4L_MASTER_TIMEOUT_EN
                    else if (to_expired) begin
                        arvalid_q     <= 1'b0;
                        rready_q      <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_write_q   <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= RESP_SLVERR;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RESP;
                    end
`endif
                end

                ST_RESP: begin
                    // Hold the response until consumed; reopen cmd with the handshake
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
`ifdef AXI4L_MASTER_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = AWPROT_DEFAULT;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = ARPROT_DEFAULT;
    assign m_axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4l_master_engine.sv
// Directed bench for axi4l_master_engine with a delay-programmable AXI4-lite slave.
// The timeout scenario is exercised only when AXI4L_MASTER_TIMEOUT_EN is defined.
module tb_axi4l_master_engine;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    axi4l_master_engine_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

    axi4l_master_engine #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .cmd_wstrb     (cmd_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_write     (rsp_write),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .rsp_timeout   (rsp_timeout),
        .m_axi         (axi.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave knobs
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          ar_delay = 0;
    int          r_delay  = 0;
    bit          ar_never = 1'b0;
    logic [1:0]  sl_bresp = 2'b00;
    logic [1:0]  sl_rresp = 2'b00;
    logic [31:0] sl_rdata = 32'h0;

    // Slave state
    int          aw_cnt, w_cnt, ar_cnt, r_cnt, b_count;
    bit          aw_seen, w_seen, ar_seen;
    logic        bvalid_r, rvalid_r;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;
    logic        aw_hs, w_hs, ar_hs;

    assign axi.awready = axi.awvalid && (aw_cnt >= aw_delay);
    assign axi.wready  = axi.wvalid && (w_cnt >= w_delay);
    assign axi.arready = axi.arvalid && !ar_never && (ar_cnt >= ar_delay);
    assign axi.bvalid  = bvalid_r;
    assign axi.bresp   = bvalid_r ? sl_bresp : 2'b00;
    assign axi.rvalid  = rvalid_r;
    assign axi.rdata   = rvalid_r ? sl_rdata : 32'h0;
    assign axi.rresp   = rvalid_r ? sl_rresp : 2'b00;
    assign aw_hs = axi.awvalid && axi.awready;
    assign w_hs  = axi.wvalid && axi.wready;
    assign ar_hs = axi.arvalid && axi.arready;

    // Behavioural slave: programmable per-channel wait states
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_count <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0;
            bvalid_r <= 1'b0; rvalid_r <= 1'b0;
            cap_awaddr <= 32'h0; cap_wdata <= 32'h0; cap_araddr <= 32'h0; cap_wstrb <= 4'h0;
        end else begin
            if (aw_hs) begin
                aw_seen <= 1'b1; cap_awaddr <= axi.awaddr; aw_cnt <= 0;
            end else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
            else aw_cnt <= 0;
            if (w_hs) begin
                w_seen <= 1'b1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb; w_cnt <= 0;
            end else if (axi.wvalid) w_cnt <= w_cnt + 1;
            else w_cnt <= 0;
            if (bvalid_r && axi.bready) begin
                bvalid_r <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; b_count <= b_count + 1;
            end else if (!bvalid_r && (aw_seen || aw_hs) && (w_seen || w_hs)) begin
                bvalid_r <= 1'b1;
            end
            if (ar_hs) begin
                ar_seen <= 1'b1; cap_araddr <= axi.araddr; ar_cnt <= 0;
            end else if (axi.arvalid) ar_cnt <= ar_cnt + 1;
            else ar_cnt <= 0;
            if (rvalid_r && axi.rready) begin
                rvalid_r <= 1'b0; ar_seen <= 1'b0; r_cnt <= 0;
            end else if (!rvalid_r && (ar_seen || ar_hs)) begin
                if (r_cnt >= r_delay) rvalid_r <= 1'b1;
                else r_cnt <= r_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command at a negedge; returns at the negedge after acceptance
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_eq("issue_ready", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int limit, output int n);
        n = 0;
        while (!rsp_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check_eq("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("hs_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("hs_cmd_ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  stable;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("rst_valids", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
        check_eq("rst_rsp", 64'({rsp_valid, rsp_write, rsp_resp, rsp_timeout}), 64'd0);
        check_eq("rst_addr_data", 64'({axi.awaddr, axi.wdata}), 64'd0);
        rst_n = 1'b1;
        check_eq("rel_cmd_ready_low", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check_eq("rel_cmd_ready_high", 64'(cmd_ready), 64'd1);

        // Zero-wait write
        issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        check_eq("w1_cmd_ready", 64'(cmd_ready), 64'd0);
        check_eq("w1_aw_w_valid", 64'({axi.awvalid, axi.wvalid, axi.bready}), 64'b111);
        check_eq("w1_awprot", 64'(axi.awprot), 64'd0);
        wait_rsp(20, n);
        check_eq("w1_latency", 64'(n), 64'd2);
        check_eq("w1_slave_addr", 64'(cap_awaddr), 64'h10);
        check_eq("w1_slave_data", 64'(cap_wdata), 64'hDEAD_BEEF);
        check_eq("w1_slave_strb", 64'(cap_wstrb), 64'hF);
        check_eq("w1_rsp", 64'({rsp_write, rsp_resp, rsp_timeout}), 64'b1_00_0);
        check_eq("w1_rdata", 64'(rsp_rdata), 64'd0);
        finish_rsp();

        // Write with AW accepted three cycles after W, DECERR response
        aw_delay = 3; sl_bresp = 2'b11;
        issue(1'b1, 32'h0000_0044, 32'hA5A5_5A5A, 4'b0101);
        @(negedge clk);
        check_eq("w2_w_dropped", 64'({axi.awvalid, axi.wvalid}), 64'b10);
        n = 0;
        while (axi.awvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("w2_aw_drop_cycles", 64'(n), 64'd3);
        wait_rsp(20, n);
        check_eq("w2_rsp_latency", 64'(n), 64'd1);
        check_eq("w2_slave_strb", 64'(cap_wstrb), 64'b0101);
        check_eq("w2_slave_addr", 64'(cap_awaddr), 64'h44);
        check_eq("w2_rsp_resp", 64'(rsp_resp), 64'b11);
        finish_rsp();
        check_eq("w2_b_count", 64'(b_count), 64'd2);
        aw_delay = 0; sl_bresp = 2'b00;

        // Read with five wait states before RVALID, SLVERR
        r_delay = 5; sl_rdata = 32'h1234_5678; sl_rresp = 2'b10;
        issue(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        check_eq("r1_ar", 64'({axi.arvalid, axi.rready, axi.arprot, axi.araddr}), {27'd0, 1'b1, 1'b1, 3'b001, 32'h20});
        wait_rsp(30, n);
        check_eq("r1_latency", 64'(n), 64'd7);
        check_eq("r1_rdata", 64'(rsp_rdata), 64'h1234_5678);
        check_eq("r1_rsp", 64'({rsp_write, rsp_resp, rsp_timeout}), 64'b0_10_0);
        finish_rsp();
        r_delay = 0;

        // Response back-pressure with a pending command held off
        sl_rdata = 32'hCAFE_F00D; sl_rresp = 2'b00;
        issue(1'b0, 32'h0000_0024, 32'h0, 4'h0);
        wait_rsp(20, n);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0090;
        cmd_wdata = 32'h0101_0202; cmd_wstrb = 4'hF;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== 32'hCAFE_F00D || rsp_resp !== 2'b00 ||
                cmd_ready || axi.awvalid) stable = 1'b0;
        end
        check_eq("bp_stable", 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("bp_hs", 64'({rsp_valid, cmd_ready, axi.awvalid}), 64'b010);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("bp_next_accept", 64'({cmd_ready, axi.awvalid}), 64'b01);
        check_eq("bp_next_addr", 64'(axi.awaddr), 64'h90);
        wait_rsp(20, n);
        check_eq("bp_next_latency", 64'(n), 64'd2);
        finish_rsp();

        // Reset while WVALID is pending
        w_delay = 20;
        issue(1'b1, 32'h0000_0060, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        check_eq("mid_wvalid", 64'(axi.wvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valids", 64'({axi.awvalid, axi.wvalid, axi.bready, cmd_ready, rsp_valid}), 64'd0);
        check_eq("mid_rst_data", 64'({axi.awaddr, axi.wdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; w_delay = 0;
        @(negedge clk);
        check_eq("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        issue(1'b1, 32'h0000_0080, 32'h0BAD_CAFE, 4'b1100);
        wait_rsp(20, n);
        check_eq("mid_new_latency", 64'(n), 64'd2);
        check_eq("mid_new_data", 64'({cap_wstrb, cap_wdata}), {28'd0, 4'b1100, 32'h0BAD_CAFE});
        check_eq("mid_new_rsp", 64'({rsp_write, rsp_resp}), 64'b1_00);
        finish_rsp();

`ifdef AXI4L_MASTER_TIMEOUT_EN
        // Hung slave: ARREADY never rises
        ar_never = 1'b1;
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        check_eq("to_arvalid_on", 64'(axi.arvalid), 64'd1);
        wait_rsp(40, n);
        check_eq("to_latency", 64'(n), 64'd16);
        check_eq("to_rsp", 64'({rsp_resp, rsp_timeout, rsp_write}), 64'b10_1_0);
        check_eq("to_bus_idle", 64'({axi.arvalid, axi.rready}), 64'd0);
        finish_rsp();
        ar_never = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
